// File: rtl/preload_pkg.sv
// Shared types and defaults for the regfile preloader.
// The REG_PRELOAD_CLEAR_EN build macro enables the zeroing sweep. It is handled in regfile_preloader.
package preload_pkg;

  localparam int NUM_REGS_DEF = 32;
  localparam int REG_W_DEF    = 5;
  localparam int DATA_W_DEF   = 32;
  localparam int TO_W         = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_RUN
  } state_e;

endpackage

// File: rtl/preload_timeout_ctr.sv
// Saturating idle-cycle counter. o_hit fires in the cycle whose increment would reach LIMIT.
module preload_timeout_ctr
  import preload_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_hit
);

  logic [TO_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr)
      r_cnt <= '0;
    else if (i_en && (r_cnt != {TO_W{1'b1}}))
      r_cnt <= r_cnt + 1'b1;
  end

  // A hit here means the counter reaches LIMIT on the coming edge.
  assign o_hit = i_en && (r_cnt >= TO_W'(LIMIT - 1));

endmodule

// File: rtl/regfile_preloader.sv
// Holds the CPU, loads (reg, value) beats through the regfile write port, then passes the CPU through.
// Build macro REG_PRELOAD_CLEAR_EN adds a zeroing sweep of r1..r(NUM_REGS-1) before the load.
module regfile_preloader
  import preload_pkg::*;
#(
  parameter int NUM_REGS       = NUM_REGS_DEF,
  parameter int REG_W          = REG_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_W-1:0]  in_reg,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              cpu_rwe,
  input  logic [REG_W-1:0]  cpu_rd,
  input  logic [DATA_W-1:0] cpu_rdata,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_rd,
  output logic [DATA_W-1:0] rf_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  state_e r_state, w_next;
  logic   w_hs, w_to_hit;

  assign w_hs = (r_state == ST_LOAD) && in_valid;

  preload_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_to (
    .i_clk (clock),
    .i_rst (reset),
    .i_clr (w_hs || (r_state != ST_LOAD)),
    .i_en  ((r_state == ST_LOAD) && !in_valid),
    .o_hit (w_to_hit)
  );

`ifdef REG_PRELOAD_CLEAR_EN
  logic [REG_W-1:0] r_idx;

  always_ff @(posedge clock) begin
    if (reset)
      r_idx <= REG_W'(1);
    else if (r_state == ST_CLEAR)
      r_idx <= r_idx + 1'b1;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      err     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_to_hit)
        err <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
`ifdef REG_PRELOAD_CLEAR_EN
        if (start) w_next = ST_CLEAR;
`else
        if (start) w_next = ST_LOAD;
`endif
      end
`ifdef REG_PRELOAD_CLEAR_EN
      ST_CLEAR: if (r_idx == REG_W'(NUM_REGS - 1)) w_next = ST_LOAD;
`endif
      // The timeout hit is gated by no-handshake, so a beat in the hit cycle wins.
      ST_LOAD: if ((w_hs && in_last) || w_to_hit) w_next = ST_RUN;
      default: w_next = r_state;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    rf_we    = 1'b0;
    rf_rd    = '0;
    rf_data  = '0;
    cpu_hold = 1'b1;
    done     = 1'b0;
    case (r_state)
`ifdef REG_PRELOAD_CLEAR_EN
      ST_CLEAR: begin
        rf_we = 1'b1;
        rf_rd = r_idx;
      end
`endif
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          rf_we   = (in_reg != '0);
          rf_rd   = in_reg;
          rf_data = in_data;
        end
      end
      ST_RUN: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
        rf_we    = cpu_rwe;
        rf_rd    = cpu_rd;
        rf_data  = cpu_rdata;
      end
      default: ;
    endcase
  end

endmodule
